// File: rtl/clkdiv_pkg.sv
// Shared encodings for the programmable clock divider.
package clkdiv_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_SQUARE  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_PULSE   = 2'b01;
    localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SHOT = 2'd2
    } state_e;

    // Encoding 2'b11 is deliberately not a pulse mode: it runs as a square wave.
    function automatic logic is_pulse(input logic [MODE_W-1:0] mode);
        return mode == MODE_PULSE;
    endfunction

endpackage

// File: rtl/clkdiv_shadow.sv
// Shadow register for divisor/mode reloads; acknowledges each applied load.
module clkdiv_shadow
    import clkdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 20
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              i_div_load,
    input  logic [WIDTH-1:0]  i_div_in,
    input  logic [MODE_W-1:0] i_mode_in,
    input  logic              i_apply,
    output logic [WIDTH-1:0]  o_sh_h,
    output logic [MODE_W-1:0] o_sh_mode,
    output logic              o_pending,
    output logic              o_div_ack
);

    logic [WIDTH-1:0]  r_sh_h;
    logic [MODE_W-1:0] r_sh_mode;
    logic              r_pending;
    logic              r_ack;

    // Capture requests (a fresh load beats an apply on the same edge) and ack applies.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sh_h    <= WIDTH'(1);
            r_sh_mode <= MODE_SQUARE;
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (i_div_load) begin
                r_sh_h    <= (i_div_in == '0) ? WIDTH'(1) : i_div_in;
                r_sh_mode <= i_mode_in;
                r_pending <= 1'b1;
            end else if (i_apply) begin
                r_pending <= 1'b0;
                r_ack     <= 1'b1;
            end
        end
    end

    assign o_sh_h    = r_sh_h;
    assign o_sh_mode = r_sh_mode;
    assign o_pending = r_pending;
    assign o_div_ack = r_ack;

endmodule

// File: rtl/clkdiv_prog.sv
// Programmable clock divider: square wave, pulse train or one-shot, with tick strobe.
module clkdiv_prog
    import clkdiv_pkg::*;
#(
    parameter int unsigned WIDTH        = 20,
    parameter int unsigned DEFAULT_HALF = 2**19
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [WIDTH-1:0]  div_in,
    input  logic [MODE_W-1:0] mode_in,
    input  logic              div_load,
    output logic              div_ack,
    output logic              clk_out,
    output logic              tick,
    output logic              busy
);

    state_e            r_state, w_state_nx;
    logic [WIDTH-1:0]  r_cnt, w_cnt_nx;
    logic [WIDTH-1:0]  r_act_h, w_act_h_nx;
    logic [MODE_W-1:0] r_act_mode, w_act_mode_nx;
    logic              r_clk_out, w_clk_out_nx;
    logic              r_tick, w_tick_nx;
    logic              r_busy;
    logic              r_en_d;

    logic              w_tc;
    logic              w_apply;
    logic              w_pending;
    logic [WIDTH-1:0]  w_sh_h;
    logic [MODE_W-1:0] w_sh_mode;

    clkdiv_shadow #(.WIDTH(WIDTH)) u_shadow (
        .clk        (clk),
        .clr        (clr),
        .i_div_load (div_load),
        .i_div_in   (div_in),
        .i_mode_in  (mode_in),
        .i_apply    (w_apply),
        .o_sh_h     (w_sh_h),
        .o_sh_mode  (w_sh_mode),
        .o_pending  (w_pending),
        .o_div_ack  (div_ack)
    );

    // Terminal count only exists while counting.
    assign w_tc = (r_state != ST_IDLE) && (r_cnt == r_act_h - WIDTH'(1));

    // State, counter and output registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_act_h    <= WIDTH'(DEFAULT_HALF);
            r_act_mode <= MODE_SQUARE;
            r_clk_out  <= 1'b0;
            r_tick     <= 1'b0;
            r_busy     <= 1'b0;
            r_en_d     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_act_h    <= w_act_h_nx;
            r_act_mode <= w_act_mode_nx;
            r_clk_out  <= w_clk_out_nx;
            r_tick     <= w_tick_nx;
            r_busy     <= (w_state_nx != ST_IDLE);
            r_en_d     <= en;
        end
    end

    // Next-state, counter and output decode; a load landing on an apply point defers the apply.
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_act_h_nx    = r_act_h;
        w_act_mode_nx = r_act_mode;
        w_clk_out_nx  = r_clk_out;
        w_tick_nx     = 1'b0;
        w_apply       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_pending && !div_load) begin
                    w_apply = 1'b1;
                end else if (en && (r_act_mode != MODE_ONESHOT)) begin
                    w_state_nx = ST_RUN;
                end else if (en && !r_en_d && (r_act_mode == MODE_ONESHOT)) begin
                    w_state_nx   = ST_SHOT;
                    w_clk_out_nx = 1'b1;
                    w_cnt_nx     = '0;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    w_state_nx = ST_IDLE;
                end else if (w_tc) begin
                    w_cnt_nx     = '0;
                    w_tick_nx    = 1'b1;
                    w_clk_out_nx = is_pulse(r_act_mode) ? 1'b1 : ~r_clk_out;
                    w_apply      = w_pending && !div_load;
                end else begin
                    w_cnt_nx = r_cnt + WIDTH'(1);
                    if (is_pulse(r_act_mode)) begin
                        w_clk_out_nx = 1'b0;
                    end
                end
            end
            ST_SHOT: begin
                if (!en) begin
                    w_state_nx   = ST_IDLE;
                    w_clk_out_nx = 1'b0;
                    w_cnt_nx     = '0;
                end else if (w_tc) begin
                    w_state_nx   = ST_IDLE;
                    w_clk_out_nx = 1'b0;
                    w_cnt_nx     = '0;
                    w_tick_nx    = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + WIDTH'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        if (w_apply) begin
            w_act_h_nx    = w_sh_h;
            w_act_mode_nx = w_sh_mode;
            w_cnt_nx      = '0;
            if (w_sh_mode != r_act_mode) begin
                w_clk_out_nx = 1'b0;
            end
            if (w_sh_mode == MODE_ONESHOT) begin
                w_state_nx = ST_IDLE;
            end
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;
    assign busy    = r_busy;

endmodule
